// File: rtl/fade_apply.sv
// rtl/fade_apply.sv - per-channel complex gain (y = x * Zc, Q1.15) with double-banked coefficients
//
// Purpose:
//   Captures the fader's per-channel complex gains into a shadow bank and
//   multiplies a multichannel complex sample stream by the active-bank gain.
//   The banks flip when the last channel of a sweep is written, so a sample
//   never sees a half-updated channel set.
//
// Ports:
//   i_clk, i_reset                    clock, asynchronous active-low reset
//   i_coef_dv/chan/real/imag          fader strobe, never back-pressured
//   i_s_valid/o_s_ready/i_s_chan/
//     i_s_real/i_s_imag               input sample stream
//   o_m_valid/i_m_ready/o_m_chan/
//     o_m_real/o_m_imag               output sample stream (4-cycle latency)
//   o_bank_swap                       one-cycle pulse after the bank flips
//
// Build option:
//   FADE_SAT_EN  defined   -> output clamps to the signed DW-bit range
//                undefined -> output wraps to the low DW bits
`timescale 1ns/1ps
module fade_apply #(
  parameter int NCHAN  = 32,
  parameter int CHAN_W = 5,
  parameter int DW     = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_coef_dv,
  input  logic [CHAN_W-1:0] i_coef_chan,
  input  logic [DW-1:0]     i_coef_real,
  input  logic [DW-1:0]     i_coef_imag,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [CHAN_W-1:0] i_s_chan,
  input  logic [DW-1:0]     i_s_real,
  input  logic [DW-1:0]     i_s_imag,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [CHAN_W-1:0] o_m_chan,
  output logic [DW-1:0]     o_m_real,
  output logic [DW-1:0]     o_m_imag,
  output logic              o_bank_swap
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam logic [DW-1:0] UNITY = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] RND = {{(SW-DW+1){1'b0}}, 1'b1, {(DW-2){1'b0}}};
`ifdef FADE_SAT_EN
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  logic [DW-1:0] r_coef_real [2][NCHAN];
  logic [DW-1:0] r_coef_imag [2][NCHAN];
  logic          r_bank_sel;
  logic          r_bank_swap;

  logic                     r_s1_valid;
  logic [CHAN_W-1:0]        r_s1_chan;
  logic signed [DW-1:0]     r_s1_a, r_s1_b, r_s1_c, r_s1_d;
  logic                     r_s2_valid;
  logic [CHAN_W-1:0]        r_s2_chan;
  logic signed [PW-1:0]     r_s2_ac, r_s2_bd, r_s2_ad, r_s2_bc;
  logic                     r_s3_valid;
  logic [CHAN_W-1:0]        r_s3_chan;
  logic signed [SW-1:0]     r_s3_re, r_s3_im;
  logic                     r_m_valid;
  logic [CHAN_W-1:0]        r_m_chan;
  logic [DW-1:0]            r_m_real, r_m_imag;

  logic w_en;
  logic w_shadow;

  // One enable for every stage: the pipeline advances whenever the output
  // register is empty or being drained.
  assign w_en     = !r_m_valid || i_m_ready;
  assign w_shadow = ~r_bank_sel;

  function automatic logic signed [SW-1:0] sext(input logic signed [PW-1:0] v);
    return {v[PW-1], v};
  endfunction

  // Drop the Q1.15 fraction bits of the rounded product sum.
  function automatic logic [DW-1:0] reduce(input logic signed [SW-1:0] v);
`ifdef FADE_SAT_EN
    logic signed [SW-1:0] sh;
    sh = v >>> (DW-1);
    if (sh > SMAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (sh < SMIN) return {1'b1, {(DW-1){1'b0}}};
    else                return sh[DW-1:0];
`else
    return DW'(v >>> (DW-1));
`endif
  endfunction

  // Coefficient banks: writes always land in the shadow bank, so the bank
  // being read by S1 is never the one being written.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < NCHAN; n++) begin
          r_coef_real[b][n] <= UNITY;
          r_coef_imag[b][n] <= '0;
        end
      end
      r_bank_sel  <= 1'b0;
      r_bank_swap <= 1'b0;
    end else begin
      r_bank_swap <= 1'b0;
      if (i_coef_dv) begin
        r_coef_real[w_shadow][i_coef_chan] <= i_coef_real;
        r_coef_imag[w_shadow][i_coef_chan] <= i_coef_imag;
        if (i_coef_chan == CHAN_W'(NCHAN-1)) begin
          r_bank_sel  <= ~r_bank_sel;
          r_bank_swap <= 1'b1;
        end
      end
    end
  end

  // Datapath. S1 reads the bank selected before this edge, so a sample
  // accepted on the swap edge still uses the old gains.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_chan  <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
      r_s1_d     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_chan  <= '0;
      r_s2_ac    <= '0;
      r_s2_bd    <= '0;
      r_s2_ad    <= '0;
      r_s2_bc    <= '0;
      r_s3_valid <= 1'b0;
      r_s3_chan  <= '0;
      r_s3_re    <= '0;
      r_s3_im    <= '0;
      r_m_valid  <= 1'b0;
      r_m_chan   <= '0;
      r_m_real   <= '0;
      r_m_imag   <= '0;
    end else if (w_en) begin
      r_s1_valid <= i_s_valid;
      r_s1_chan  <= i_s_chan;
      r_s1_a     <= i_s_real;
      r_s1_b     <= i_s_imag;
      r_s1_c     <= r_coef_real[r_bank_sel][i_s_chan];
      r_s1_d     <= r_coef_imag[r_bank_sel][i_s_chan];

      r_s2_valid <= r_s1_valid;
      r_s2_chan  <= r_s1_chan;
      r_s2_ac    <= r_s1_a * r_s1_c;
      r_s2_bd    <= r_s1_b * r_s1_d;
      r_s2_ad    <= r_s1_a * r_s1_d;
      r_s2_bc    <= r_s1_b * r_s1_c;

      r_s3_valid <= r_s2_valid;
      r_s3_chan  <= r_s2_chan;
      r_s3_re    <= sext(r_s2_ac) - sext(r_s2_bd) + RND;
      r_s3_im    <= sext(r_s2_ad) + sext(r_s2_bc) + RND;

      r_m_valid  <= r_s3_valid;
      r_m_chan   <= r_s3_chan;
      r_m_real   <= reduce(r_s3_re);
      r_m_imag   <= reduce(r_s3_im);
    end
  end

  assign o_s_ready   = w_en;
  assign o_m_valid   = r_m_valid;
  assign o_m_chan    = r_m_chan;
  assign o_m_real    = r_m_real;
  assign o_m_imag    = r_m_imag;
  assign o_bank_swap = r_bank_swap;

endmodule

// File: tb/tb_fade_apply.sv
// tb/tb_fade_apply.sv - scoreboard bench for fade_apply against an arithmetic gain model
`timescale 1ns/1ps
module tb_fade_apply;

  localparam int NCHAN  = 32;
  localparam int CHAN_W = 5;
  localparam int DW     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              coef_dv;
  logic [CHAN_W-1:0] coef_chan;
  logic [DW-1:0]     coef_real, coef_imag;
  logic              s_valid, s_ready;
  logic [CHAN_W-1:0] s_chan;
  logic [DW-1:0]     s_real, s_imag;
  logic              m_valid, m_ready;
  logic [CHAN_W-1:0] m_chan;
  logic [DW-1:0]     m_real, m_imag;
  logic              bank_swap;

  always #5 clk = ~clk;

  fade_apply #(.NCHAN(NCHAN), .CHAN_W(CHAN_W), .DW(DW)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_coef_dv   (coef_dv),
    .i_coef_chan (coef_chan),
    .i_coef_real (coef_real),
    .i_coef_imag (coef_imag),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .i_s_chan    (s_chan),
    .i_s_real    (s_real),
    .i_s_imag    (s_imag),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_m_chan    (m_chan),
    .o_m_real    (m_real),
    .o_m_imag    (m_imag),
    .o_bank_swap (bank_swap)
  );

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [DW-1:0]     re;
    logic [DW-1:0]     im;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gain_re [2][NCHAN];
  int   gain_im [2][NCHAN];
  int   active = 0;
  logic swap_exp = 1'b0;
  logic swap_pipe = 1'b0;
  int   swap_seen = 0;

  function automatic int to_s(input int x);
    logic [DW-1:0] t;
    t = x[DW-1:0];
    return int'($signed(t));
  endfunction

  function automatic int rnd16();
    if ($urandom % 8 == 0) return 'h8000;
    if ($urandom % 8 == 0) return 'h7FFF;
    return int'($urandom_range(0, 65535));
  endfunction

  // Q1.15 product sum back to Q1.15: add half an LSB, floor-divide by 2^15.
  function automatic logic [DW-1:0] reduce(input longint v);
    longint q;
    q = (v + (longint'(1) << (DW-2))) >>> (DW-1);
`ifdef FADE_SAT_EN
    if (q > (longint'(1) << (DW-1)) - 1) q = (longint'(1) << (DW-1)) - 1;
    else if (q < -(longint'(1) << (DW-1))) q = -(longint'(1) << (DW-1));
`endif
    return q[DW-1:0];
  endfunction

  function automatic exp_t predict(input int ch, input int a, input int b);
    exp_t   e;
    longint c, d;
    c = gain_re[active][ch];
    d = gain_im[active][ch];
    e.chan = CHAN_W'(ch);
    e.re   = reduce(longint'(a) * c - longint'(b) * d);
    e.im   = reduce(longint'(a) * d + longint'(b) * c);
    return e;
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int n = 0; n < NCHAN; n++) begin
        gain_re[b][n] = 32767;
        gain_im[b][n] = 0;
      end
    active = 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // One clock of stimulus; the model is updated in the same order the
  // hardware sees the edge: sample uses current gains, then the write lands.
  task automatic cycle(input bit sv, input int sch, input int sr, input int si,
                       input bit cdv, input int cch, input int cr, input int ci,
                       input bit mr);
    @(negedge clk);
    swap_exp  = swap_pipe;
    swap_pipe = 1'b0;
    s_valid   = sv;
    s_chan    = CHAN_W'(sch);
    s_real    = DW'(sr);
    s_imag    = DW'(si);
    coef_dv   = cdv;
    coef_chan = CHAN_W'(cch);
    coef_real = DW'(cr);
    coef_imag = DW'(ci);
    m_ready   = mr;
    #1;
    if (sv && s_ready) sb.push_back(predict(sch, to_s(sr), to_s(si)));
    if (cdv) begin
      gain_re[1-active][cch] = to_s(cr);
      gain_im[1-active][cch] = to_s(ci);
      if (cch == NCHAN-1) begin
        active    = 1 - active;
        swap_pipe = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      idle(1);
      n++;
    end
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d samples outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic sweep(input int cr, input int ci);
    for (int ch = 0; ch < NCHAN; ch++) cycle(0, 0, 0, 0, 1, ch, cr, ci, 1);
  endtask

  // Monitor: checks every transfer against the scoreboard and the hold rule.
  logic              held_v = 1'b0;
  logic [CHAN_W-1:0] h_chan;
  logic [DW-1:0]     h_re, h_im;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("bank_swap", {63'd0, bank_swap}, {63'd0, swap_exp});
        if (bank_swap) swap_seen++;
        chk("s_ready", {63'd0, s_ready}, {63'd0, (!m_valid || m_ready)});
        if (held_v) begin
          checks++;
          if (!m_valid || m_chan !== h_chan || m_real !== h_re || m_imag !== h_im) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b chan=%0d re=%h im=%h, required v=1 chan=%0d re=%h im=%h",
                     m_valid, m_chan, m_real, m_imag, h_chan, h_re, h_im);
          end
        end
        if (m_valid && m_ready) begin
          held_v = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got chan=%0d re=%h im=%h, required no output",
                     m_chan, m_real, m_imag);
          end else begin
            e = sb.pop_front();
            if (m_chan !== e.chan || m_real !== e.re || m_imag !== e.im) begin
              errors++;
              $display("FAIL sample: got chan=%0d re=%h im=%h, required chan=%0d re=%h im=%h",
                       m_chan, m_real, m_imag, e.chan, e.re, e.im);
            end
          end
        end else if (m_valid) begin
          held_v = 1'b1;
          h_chan = m_chan;
          h_re   = m_real;
          h_im   = m_imag;
        end else begin
          held_v = 1'b0;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int sw0;
    int acc;
    int iter;

    rst_n = 1'b0;
    s_valid = 1'b0; s_chan = '0; s_real = '0; s_imag = '0;
    coef_dv = 1'b0; coef_chan = '0; coef_real = '0; coef_imag = '0;
    m_ready = 1'b1;
    model_reset();
    #1;
    chk("reset_m_valid", {63'd0, m_valid}, 64'd0);
    chk("reset_m_chan", {59'd0, m_chan}, 64'd0);
    chk("reset_m_real", {48'd0, m_real}, 64'd0);
    chk("reset_m_imag", {48'd0, m_imag}, 64'd0);
    chk("reset_bank_swap", {63'd0, bank_swap}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unity gain after reset.
    cycle(1, 3, 'h4000, 'h2000, 0, 0, 0, 0, 1);
    drain(20);

    // Full sweep to (0, 0x7FFF), then a sample through the new bank.
    sw0 = swap_seen;
    sweep('h0000, 'h7FFF);
    cycle(1, $urandom_range(0, NCHAN-1), 'h4000, 'h0000, 0, 0, 0, 0, 1);
    drain(20);
    chk("swap_count_sweep", 64'(swap_seen - sw0), 64'd1);

    // Continuous stream while a sweep writes random gains.
    for (int i = 0; i < 40; i++)
      cycle(1, $urandom_range(0, NCHAN-1), rnd16(), rnd16(),
            i < NCHAN, i, rnd16(), rnd16(), 1);
    drain(20);

    // Random traffic: 50% back-pressure, sporadic writes and swaps.
    acc = 0;
    iter = 0;
    while (acc < 1000 && iter < 8000) begin
      bit sv;
      bit cdv;
      int n0;
      sv  = ($urandom % 4) != 0;
      cdv = ($urandom % 4) == 0;
      n0  = sb.size();
      cycle(sv, $urandom_range(0, NCHAN-1), rnd16(), rnd16(),
            cdv, (($urandom % 4) == 0) ? NCHAN-1 : $urandom_range(0, NCHAN-1),
            rnd16(), rnd16(), $urandom % 2);
      if (sb.size() > n0) acc++;
      iter++;
    end
    chk("random_accepted", 64'(acc), 64'd1000);
    drain(200);

    // Overflow corner.
    sweep('h8000, 'h8000);
    cycle(1, 5, 'h8000, 'h8000, 0, 0, 0, 0, 1);
    drain(20);

    // Reset with a full, stalled pipeline.
    sweep('h2000, 'h1000);
    for (int i = 0; i < 6; i++)
      cycle(1, $urandom_range(0, NCHAN-1), rnd16(), rnd16(), 0, 0, 0, 0, 0);
    #2;
    chk("pre_reset_m_valid", {63'd0, m_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_m_valid", {63'd0, m_valid}, 64'd0);
    chk("midreset_m_real", {48'd0, m_real}, 64'd0);
    sb.delete();
    model_reset();
    swap_exp  = 1'b0;
    swap_pipe = 1'b0;
    s_valid   = 1'b0;
    coef_dv   = 1'b0;
    m_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 7, 'h4000, 'h2000, 0, 0, 0, 0, 1);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
